gcbp_bram_reader: RTL and testbench
===================================

GCBP_BRAM_READER -- requirements
Module: gcbp_bram_reader

Interface
REQ-001 SHALL have parameter C_SUBIMAGE_HEIGHT, default 64, meaning lines per sub image; it SHALL be a power of two, at most 64.
REQ-002 SHALL have parameter C_NUM_SUBIMAGES, default 16, meaning BRAMs/sub images in the array (4x4).
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_resetn  input  1  reset, synchronous, active-low.
REQ-005 i_start  input  1  one-cycle pulse to begin reading one frame pair.
REQ-006 i_curr_frame_loc  input  2  BRAM region holding the current frame; sampled on accepted i_start.
REQ-007 i_prev_frame_loc  input  2  BRAM region holding the previous frame; sampled on accepted i_start.
REQ-008 o_bram_array_read_addr  output  9  read address shared by all BRAMs, equal to {1'b0, frame_loc[1:0], line[5:0]}.
REQ-009 i_bram_array_read_data  input  2048  concatenated read data; BRAM n occupies bits [128n+127:128n]; data is valid 1 cycle after its address.
REQ-010 o_curr_line / o_prev_line  output  128 each  sub image line from the current and previous frame.
REQ-011 o_line_valid  output  1  output line valid; i_ready  input  1  consumer accepts when o_line_valid and i_ready are both high.
REQ-012 o_subimage_idx  output  4  index of the sub image (vert*4+hori, same as the write-enable bit); o_line_idx  output  6  line within the sub image.
REQ-013 o_subimage_last  output  1  high with the last line of a sub image.
REQ-014 o_frame_done  output  1  one-cycle pulse after the final line is accepted.
REQ-015 o_busy  output  1  high from accepted i_start until o_frame_done.

Function
REQ-016 FSM states SHALL be S_IDLE, S_RD_CURR, S_RD_PREV, S_CAPTURE, S_OUT.
REQ-017 S_IDLE: i_start moves the FSM to S_RD_CURR, latches both frame locations, and clears the sub image and line counters.
REQ-018 S_RD_CURR: drive the address using the latched current-frame location; go to S_RD_PREV.
REQ-019 S_RD_PREV: register the selected BRAM slice into o_curr_line; drive the address using the latched previous-frame location; go to S_CAPTURE.
REQ-020 S_CAPTURE: register the selected slice into o_prev_line; set o_line_valid; go to S_OUT.
REQ-021 S_OUT: hold all outputs stable while i_ready is low.
REQ-022 On handshake in S_OUT: clear o_line_valid; increment the line counter, wrapping at C_SUBIMAGE_HEIGHT-1 and then incrementing the sub image index.
REQ-023 After the handshake on sub image 15, line 63: pulse o_frame_done, return to S_IDLE, and clear o_busy.
REQ-024 Otherwise the FSM SHALL return to S_RD_CURR; minimum throughput is one line per 4 cycles.
REQ-025 BRAM slice selection SHALL use the registered sub image index.
REQ-026 o_subimage_last = (line counter == C_SUBIMAGE_HEIGHT-1) && o_line_valid.
REQ-027 i_start while o_busy SHALL be ignored; the latched locations SHALL be unchanged.
REQ-028 i_curr_frame_loc == i_prev_frame_loc SHALL be accepted without special handling; both lines are then equal.
REQ-029 Counters SHALL never wrap past sub image 15; the count is exactly 16*64 = 1024 handshakes per frame.
REQ-030 o_bram_array_read_addr SHALL be 0 in S_IDLE.

Reset
REQ-031 With i_resetn low at a clock edge, the FSM SHALL go to S_IDLE.
REQ-032 Reset SHALL clear o_line_valid, o_frame_done, o_busy, o_subimage_idx, o_line_idx, o_curr_line, o_prev_line and the latched locations.
REQ-033 Reset mid-frame SHALL abort the frame with no o_frame_done pulse; the next i_start restarts from sub image 0, line 0.

Configuration
REQ-034 Macro GCBP_RD_XOR_EN SHALL add output o_xor_line (128): registered o_curr_line ^ o_prev_line, valid with o_line_valid and updated in S_CAPTURE.
REQ-035 Without GCBP_RD_XOR_EN, o_xor_line SHALL be driven constant 0 and no XOR registers SHALL be inferred; all other behaviour is identical.

Verification
REQ-036 Reset then idle: 10 cycles with i_start=0 -> o_busy=0, o_line_valid=0, addr=0.
REQ-037 Full frame, i_ready=1, curr_loc=1, prev_loc=0, model BRAM word = {n, loc, line} -> 1024 lines in order; sub image 5, line 3 has addresses 0x043 then 0x003; o_frame_done once.
REQ-038 Backpressure: i_ready low 7 cycles on line 10 -> outputs stable all 7 cycles, no line skipped or repeated.
REQ-039 i_start re-pulsed mid-frame with locs 3/2 -> ignored; addresses keep using 1/0.
REQ-040 Reset asserted at sub image 8, line 20 -> o_line_valid=0 next cycle, no o_frame_done; a new i_start begins at sub image 0, line 0.
REQ-041 GCBP_RD_XOR_EN defined, curr=all-ones, prev=0x00FF..00FF -> o_xor_line=0xFF00..FF00; undefined -> o_xor_line=0.

Source files
------------

// File: rtl/gcbp_bram_reader.sv
// gcbp_bram_reader
// Reads one current/previous frame pair out of a 4x4 array of sub image BRAMs,
// one line at a time, and presents each line pair to a ready/valid consumer.
// Every line takes a current-frame read, a previous-frame read, a capture cycle
// and an output cycle, so an always-ready consumer sees one line every 4 cycles.
// Optional feature: define GCBP_RD_XOR_EN to register o_curr_line ^ o_prev_line
// onto o_xor_line; without it o_xor_line is tied to zero.
module gcbp_bram_reader #(
    parameter int C_SUBIMAGE_HEIGHT = 64,
    parameter int C_NUM_SUBIMAGES   = 16
) (
    input  logic                           i_clk,
    input  logic                           i_resetn,
    input  logic                           i_start,
    input  logic [1:0]                     i_curr_frame_loc,
    input  logic [1:0]                     i_prev_frame_loc,
    output logic [8:0]                     o_bram_array_read_addr,
    input  logic [C_NUM_SUBIMAGES*128-1:0] i_bram_array_read_data,
    output logic [127:0]                   o_curr_line,
    output logic [127:0]                   o_prev_line,
    output logic [127:0]                   o_xor_line,
    output logic                           o_line_valid,
    input  logic                           i_ready,
    output logic [3:0]                     o_subimage_idx,
    output logic [5:0]                     o_line_idx,
    output logic                           o_subimage_last,
    output logic                           o_frame_done,
    output logic                           o_busy
);

    localparam logic [5:0] LAST_LINE = 6'(C_SUBIMAGE_HEIGHT - 1);
    localparam logic [3:0] LAST_SUB  = 4'(C_NUM_SUBIMAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CURR,
        S_RD_PREV,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   curr_loc_q, curr_loc_d;
    logic [1:0]   prev_loc_q, prev_loc_d;
    logic [3:0]   sub_idx_q, sub_idx_d;
    logic [5:0]   line_idx_q, line_idx_d;
    logic [127:0] curr_line_q, curr_line_d;
    logic [127:0] prev_line_q, prev_line_d;
    logic         line_valid_q, line_valid_d;
    logic         frame_done_q, frame_done_d;
    logic [8:0]   read_addr;
    logic [127:0] bram_slice;

    // Pick the 128-bit word of the BRAM that belongs to the registered sub image
    always_comb begin
        bram_slice = i_bram_array_read_data[{sub_idx_q, 7'd0} +: 128];
    end

    // Next-state logic, address generation and line/sub image bookkeeping
    always_comb begin
        state_d      = state_q;
        curr_loc_d   = curr_loc_q;
        prev_loc_d   = prev_loc_q;
        sub_idx_d    = sub_idx_q;
        line_idx_d   = line_idx_q;
        curr_line_d  = curr_line_q;
        prev_line_d  = prev_line_q;
        line_valid_d = line_valid_q;
        frame_done_d = 1'b0;
        read_addr    = 9'd0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_RD_CURR;
                    curr_loc_d = i_curr_frame_loc;
                    prev_loc_d = i_prev_frame_loc;
                    sub_idx_d  = 4'd0;
                    line_idx_d = 6'd0;
                end
            end
            S_RD_CURR: begin
                read_addr = {1'b0, curr_loc_q, line_idx_q};
                state_d   = S_RD_PREV;
            end
            S_RD_PREV: begin
                curr_line_d = bram_slice;
                read_addr   = {1'b0, prev_loc_q, line_idx_q};
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                prev_line_d  = bram_slice;
                line_valid_d = 1'b1;
                state_d      = S_OUT;
            end
            S_OUT: begin
                if (i_ready) begin
                    line_valid_d = 1'b0;
                    state_d      = S_RD_CURR;
                    if (line_idx_q == LAST_LINE) begin
                        line_idx_d = 6'd0;
                        if (sub_idx_q == LAST_SUB) begin
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            sub_idx_d = sub_idx_q + 4'd1;
                        end
                    end else begin
                        line_idx_d = line_idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q      <= S_IDLE;
            curr_loc_q   <= 2'd0;
            prev_loc_q   <= 2'd0;
            sub_idx_q    <= 4'd0;
            line_idx_q   <= 6'd0;
            curr_line_q  <= 128'd0;
            prev_line_q  <= 128'd0;
            line_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_loc_q   <= curr_loc_d;
            prev_loc_q   <= prev_loc_d;
            sub_idx_q    <= sub_idx_d;
            line_idx_q   <= line_idx_d;
            curr_line_q  <= curr_line_d;
            prev_line_q  <= prev_line_d;
            line_valid_q <= line_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef GCBP_RD_XOR_EN
    logic [127:0] xor_line_q, xor_line_d;

    // Difference line is formed alongside the previous-line capture
    always_comb begin
        xor_line_d = xor_line_q;
        if (state_q == S_CAPTURE) begin
            xor_line_d = curr_line_q ^ bram_slice;
        end
    end

    // Difference line register
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            xor_line_q <= 128'd0;
        end else begin
            xor_line_q <= xor_line_d;
        end
    end

    assign o_xor_line = xor_line_q;
`else
    assign o_xor_line = 128'd0;
`endif

    assign o_bram_array_read_addr = read_addr;
    assign o_curr_line            = curr_line_q;
    assign o_prev_line            = prev_line_q;
    assign o_line_valid           = line_valid_q;
    assign o_subimage_idx         = sub_idx_q;
    assign o_line_idx             = line_idx_q;
    assign o_subimage_last        = (line_idx_q == LAST_LINE) && line_valid_q;
    assign o_frame_done           = frame_done_q;
    assign o_busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// Testbench for gcbp_bram_reader: a BRAM array model answers reads one cycle
// late, and a line-level reference model predicts every output each cycle.
module tb_gcbp_bram_reader;

    localparam int H = 64;
    localparam int N = 16;

    logic           i_clk = 1'b0;
    logic           i_resetn = 1'b0;
    logic           i_start = 1'b0;
    logic [1:0]     i_curr_frame_loc = 2'd0;
    logic [1:0]     i_prev_frame_loc = 2'd0;
    logic [8:0]     o_bram_array_read_addr;
    logic [N*128-1:0] i_bram_array_read_data = '0;
    logic [127:0]   o_curr_line;
    logic [127:0]   o_prev_line;
    logic [127:0]   o_xor_line;
    logic           o_line_valid;
    logic           i_ready = 1'b0;
    logic [3:0]     o_subimage_idx;
    logic [5:0]     o_line_idx;
    logic           o_subimage_last;
    logic           o_frame_done;
    logic           o_busy;

    always #5 i_clk = ~i_clk;

    gcbp_bram_reader #(
        .C_SUBIMAGE_HEIGHT(H),
        .C_NUM_SUBIMAGES  (N)
    ) dut (
        .i_clk                 (i_clk),
        .i_resetn              (i_resetn),
        .i_start               (i_start),
        .i_curr_frame_loc      (i_curr_frame_loc),
        .i_prev_frame_loc      (i_prev_frame_loc),
        .o_bram_array_read_addr(o_bram_array_read_addr),
        .i_bram_array_read_data(i_bram_array_read_data),
        .o_curr_line           (o_curr_line),
        .o_prev_line           (o_prev_line),
        .o_xor_line            (o_xor_line),
        .o_line_valid          (o_line_valid),
        .i_ready               (i_ready),
        .o_subimage_idx        (o_subimage_idx),
        .o_line_idx            (o_line_idx),
        .o_subimage_last       (o_subimage_last),
        .o_frame_done          (o_frame_done),
        .o_busy                (o_busy)
    );

    // BRAM contents: either a tagged word {salt, n, addr} or a fixed XOR pattern
    logic [95:0] salt = 96'd0;
    bit          pat_mode = 1'b0;
    logic [1:0]  pat_curr_loc = 2'd0;

    function automatic logic [127:0] bram_word(input int n, input logic [8:0] addr);
        if (pat_mode) begin
            return (addr[7:6] == pat_curr_loc) ? {128{1'b1}} : {8{16'h00FF}};
        end
        return {salt, 16'(n), 7'd0, addr};
    endfunction

    // BRAM array: registered read, data one cycle after the address
    always @(posedge i_clk) begin
        for (int n = 0; n < N; n++) begin
            i_bram_array_read_data[n*128 +: 128] <= bram_word(n, o_bram_array_read_addr);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit         active = 1'b0;
    bit         post_reset = 1'b1;
    bit         done_next = 1'b0;
    bit         prev_valid_exp = 1'b0;
    int         cd = 0;
    int         exp_sub = 0;
    int         exp_line = 0;
    logic [1:0] m_curr = 2'd0;
    logic [1:0] m_prev = 2'd0;
    logic [8:0] hist [4];
    int         done_cnt = 0;
    int         dut_lines = 0;
    bit         dut_valid_prev = 1'b0;

    // Inputs to apply on the next cycle
    logic       nx_resetn = 1'b0;
    logic       nx_start = 1'b0;
    logic       nx_ready = 1'b0;
    logic [1:0] nx_curr = 2'd0;
    logic [1:0] nx_prev = 2'd0;

    // One clock cycle: check outputs at the falling edge, then drive and predict
    task automatic applyStimulus;
        bit           done_exp;
        bit           valid_exp;
        logic [127:0] exp_c;
        logic [127:0] exp_p;
        logic [127:0] exp_x;
        @(negedge i_clk);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = o_bram_array_read_addr;
        if (active && cd > 0) cd--;
        done_exp  = done_next;
        done_next = 1'b0;
        if (o_frame_done === 1'b1) done_cnt++;
        if (o_line_valid === 1'b1 && !dut_valid_prev) dut_lines++;
        dut_valid_prev = (o_line_valid === 1'b1);

        checkOutput("frame_done", 128'(o_frame_done), 128'(done_exp));
        checkOutput("busy", 128'(o_busy), 128'(active));
        valid_exp = active && (cd == 0);
        checkOutput("line_valid", 128'(o_line_valid), 128'(valid_exp));
        if (!active) checkOutput("idle_addr", 128'(o_bram_array_read_addr), 128'd0);
        if (post_reset) begin
            checkOutput("rst_sub_idx", 128'(o_subimage_idx), 128'd0);
            checkOutput("rst_line_idx", 128'(o_line_idx), 128'd0);
            checkOutput("rst_curr_line", o_curr_line, 128'd0);
            checkOutput("rst_prev_line", o_prev_line, 128'd0);
        end
        if (valid_exp) begin
            exp_c = bram_word(exp_sub, {1'b0, m_curr, 6'(exp_line)});
            exp_p = bram_word(exp_sub, {1'b0, m_prev, 6'(exp_line)});
`ifdef GCBP_RD_XOR_EN
            exp_x = exp_c ^ exp_p;
`else
            exp_x = 128'd0;
`endif
            checkOutput("curr_line", o_curr_line, exp_c);
            checkOutput("prev_line", o_prev_line, exp_p);
            checkOutput("xor_line", o_xor_line, exp_x);
            checkOutput("sub_idx", 128'(o_subimage_idx), 128'(exp_sub));
            checkOutput("line_idx", 128'(o_line_idx), 128'(exp_line));
            checkOutput("sub_last", 128'(o_subimage_last), 128'(exp_line == H - 1));
            if (!prev_valid_exp) begin
                checkOutput("addr_curr", 128'(hist[3]), 128'({1'b0, m_curr, 6'(exp_line)}));
                checkOutput("addr_prev", 128'(hist[2]), 128'({1'b0, m_prev, 6'(exp_line)}));
            end
        end
        prev_valid_exp = valid_exp;

        i_resetn         = nx_resetn;
        i_start          = nx_start;
        i_ready          = nx_ready;
        i_curr_frame_loc = nx_curr;
        i_prev_frame_loc = nx_prev;

        if (!nx_resetn) begin
            active     = 1'b0;
            cd         = 0;
            done_next  = 1'b0;
            post_reset = 1'b1;
        end else if (!active && nx_start) begin
            active     = 1'b1;
            cd         = 4;
            m_curr     = nx_curr;
            m_prev     = nx_prev;
            exp_sub    = 0;
            exp_line   = 0;
            post_reset = 1'b0;
        end else if (valid_exp && nx_ready) begin
            cd = 4;
            if (exp_line == H - 1) begin
                exp_line = 0;
                if (exp_sub == N - 1) begin
                    active    = 1'b0;
                    cd        = 0;
                    done_next = 1'b1;
                end else begin
                    exp_sub++;
                end
            end else begin
                exp_line++;
            end
        end
    endtask

    // mode 0: backpressure + ignored restart, 1: random ready, 2: abort by reset, 3: always ready
    task automatic runFrame(input logic [1:0] curr, input logic [1:0] prev, input int mode);
        int  cycles;
        int  bp;
        bit  repulsed;
        bit  aborted;
        bit  will_valid;
        cycles    = 0;
        bp        = 0;
        repulsed  = 1'b0;
        aborted   = 1'b0;
        done_cnt  = 0;
        dut_lines = 0;
        nx_resetn = 1'b1;
        nx_curr   = curr;
        nx_prev   = prev;
        nx_start  = 1'b1;
        nx_ready  = 1'b1;
        applyStimulus();
        nx_start = 1'b0;
        while (active && cycles < 12000) begin
            will_valid = active && (cd <= 1);
            nx_start   = 1'b0;
            nx_resetn  = 1'b1;
            nx_ready   = 1'b1;
            case (mode)
                0: begin
                    if (will_valid && exp_sub == 0 && exp_line == 10 && bp < 7) begin
                        nx_ready = 1'b0;
                        bp++;
                    end
                    if (exp_sub == 2 && exp_line == 5 && !repulsed) begin
                        nx_start = 1'b1;
                        nx_curr  = 2'd3;
                        nx_prev  = 2'd2;
                        repulsed = 1'b1;
                    end
                end
                1: nx_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (will_valid && exp_sub == 8 && exp_line == 20 && !aborted) begin
                        nx_resetn = 1'b0;
                        aborted   = 1'b1;
                    end
                end
                default: nx_ready = 1'b1;
            endcase
            applyStimulus();
            cycles++;
        end
        if (cycles >= 12000) checkOutput("frame_timeout", 128'd1, 128'd0);
        nx_resetn = 1'b1;
        nx_start  = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        if (mode == 2) begin
            checkOutput("abort_no_done", 128'(done_cnt), 128'd0);
        end else begin
            checkOutput("frame_lines", 128'(dut_lines), 128'd1024);
            checkOutput("done_once", 128'(done_cnt), 128'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 9'd0;
        $display("[TB] reset and idle");
        nx_resetn = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        nx_resetn = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus();

        $display("[TB] frame 1: curr=1 prev=0, backpressure, ignored restart");
        salt = {$urandom, $urandom, $urandom};
        runFrame(2'd1, 2'd0, 0);

        $display("[TB] frame 2: random locations and ready");
        salt = {$urandom, $urandom, $urandom};
        runFrame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);

        $display("[TB] frame 3: reset at sub image 8 line 20");
        salt = {$urandom, $urandom, $urandom};
        runFrame(2'd2, 2'd1, 2);

        $display("[TB] frame 4: XOR pattern");
        pat_mode     = 1'b1;
        pat_curr_loc = 2'd3;
        runFrame(2'd3, 2'd0, 3);
        pat_mode = 1'b0;

        $display("[TB] frame 5: equal locations");
        salt = {$urandom, $urandom, $urandom};
        runFrame(2'd2, 2'd2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
